boot_rom_arbiter: RTL and testbench

- Shares the single-port 1024x32 boot ROM between the instruction-fetch port and the data-load port of the RV32 core.
- Decodes byte addresses and arbitrates round-robin, accepting at most one access per cycle.
- Drives the ROM's ce/oce/ad pins and routes the synchronous ROM output back to the requester that issued each access, in order, with fixed latency.
- Sits between the core bus interfaces and the ROM primitive wrapper in the SoC top.

---
 rtl/boot_rom_arbiter_pkg.sv | 18 +
 rtl/boot_rom_arbiter_if.sv | 38 +++
 rtl/boot_rom_arbiter_rr_arbiter2.sv | 30 +++
 rtl/boot_rom_arbiter.sv | 85 ++++++++
 tb/tb_boot_rom_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_rom_arbiter_pkg.sv
// Shared SoC definitions for the boot ROM path: requester ids, the in-flight
// tracking entry and the ROM window base address.
package boot_rom_arbiter_pkg;

    localparam logic [31:0] BOOT_ROM_BASE = 32'h0000_0000;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
        logic     err;
    } inflight_t;

endpackage

// File: rtl/boot_rom_arbiter_if.sv
// Core-side fetch/load request channels plus the ROM primitive pins.
// slave = the arbiter, master = the surrounding core and ROM.
interface boot_rom_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              d_req;
    logic [31:0]       d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              rom_ce;
    logic              rom_oce;
    logic [ADDR_W-1:0] rom_ad;
    logic [31:0]       rom_dout;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, rom_dout,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output rom_ce, rom_oce, rom_ad
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, rom_dout,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  rom_ce, rom_oce, rom_ad
    );
endinterface

// File: rtl/boot_rom_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; on conflict the port not granted last wins.
module rr_arbiter2
    import boot_rom_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    port_id_t last_grant;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (req_a && (!req_b || last_grant == PORT_D)) gnt_a = 1'b1;
            else if (req_b)                                gnt_b = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)      last_grant <= PORT_D;
        else if (gnt_a) last_grant <= PORT_IF;
        else if (gnt_b) last_grant <= PORT_D;
    end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares the single-port boot ROM between fetch and load ports: decode,
// round-robin issue, and in-order fixed-latency response routing.
module boot_rom_arbiter
    import boot_rom_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter logic [31:0] BASE_ADDR  = BOOT_ROM_BASE,
    parameter int unsigned RD_LATENCY = 1
) (
    input logic              clk,
    input logic              reset,
    boot_rom_arbiter_if.slave bus
);

    localparam logic [31:0] ROM_BYTES = 32'd4 << ADDR_W;

    logic        gnt_if;
    logic        gnt_d;
    logic        accept;
    logic [31:0] sel_addr;
    logic [31:0] offset;
    logic        ok;
    inflight_t   push;
    inflight_t   tail;
    logic        resp_v;
    logic        rv_if;
    logic        rv_d;
    inflight_t   pipe [RD_LATENCY];

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_a (bus.if_req),
        .req_b (bus.d_req),
        .gnt_a (gnt_if),
        .gnt_b (gnt_d)
    );

    // Wrapping subtraction makes addresses below the base fall out of range.
    always_comb begin
        accept     = gnt_if | gnt_d;
        sel_addr   = gnt_d ? bus.d_addr : bus.if_addr;
        offset     = sel_addr - BASE_ADDR;
        ok         = accept && (offset < ROM_BYTES) && (sel_addr[1:0] == 2'b00);
        push.valid = accept;
        push.port  = gnt_d ? PORT_D : PORT_IF;
        push.err   = accept && !ok;
    end

    always_comb begin
        bus.if_gnt = gnt_if;
        bus.d_gnt  = gnt_d;
        bus.rom_ce = ok;
        bus.rom_ad = ok ? offset[ADDR_W+1:2] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= push;
            for (int unsigned i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    if (RD_LATENCY == 1) begin : g_bypass
        always_comb bus.rom_oce = bus.rom_ce;
    end else begin : g_pipelined
        always_comb bus.rom_oce = pipe[0].valid && !pipe[0].err && !reset;
    end

    always_comb begin
        tail          = pipe[RD_LATENCY-1];
        resp_v        = tail.valid && !reset;
        rv_if         = resp_v && (tail.port == PORT_IF);
        rv_d          = resp_v && (tail.port == PORT_D);
        bus.if_rvalid = rv_if;
        bus.if_err    = rv_if && tail.err;
        bus.if_rdata  = (rv_if && !tail.err) ? bus.rom_dout : '0;
        bus.d_rvalid  = rv_d;
        bus.d_err     = rv_d && tail.err;
        bus.d_rdata   = (rv_d && !tail.err) ? bus.rom_dout : '0;
    end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Scoreboard bench: two arbiters (bypass and pipelined ROM) share one stimulus
// stream; a predictor queues expected responses and a monitor retires them.
module tb_boot_rom_arbiter;
    import boot_rom_arbiter_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req;
    logic [31:0] if_addr, d_addr;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    boot_rom_arbiter_if #(.ADDR_W(ADDR_W)) b1 ();
    boot_rom_arbiter_if #(.ADDR_W(ADDR_W)) b2 ();

    boot_rom_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .RD_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    boot_rom_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .RD_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave));

    assign b1.if_req  = if_req;
    assign b1.if_addr = if_addr;
    assign b1.d_req   = d_req;
    assign b1.d_addr  = d_addr;
    assign b2.if_req  = if_req;
    assign b2.if_addr = if_addr;
    assign b2.d_req   = d_req;
    assign b2.d_addr  = d_addr;

    function automatic logic [31:0] rom_word(input int unsigned a);
        case (a)
            0:       return 32'h300002B7;
            1:       return 32'h00029313;
            2:       return 32'h0062A023;
            default: return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
        endcase
    endfunction

    // ROM primitive models: bypass (ce only) and output-register (ce then oce).
    logic [31:0] mem [1024];
    logic [31:0] r1_q, r2_q1, r2_q2;
    initial for (int i = 0; i < 1024; i++) mem[i] = rom_word(i);
    always @(posedge clk) if (b1.rom_ce) r1_q <= mem[b1.rom_ad];
    always @(posedge clk) begin
        if (b2.rom_ce)  r2_q1 <= mem[b2.rom_ad];
        if (b2.rom_oce) r2_q2 <= r2_q1;
    end
    assign b1.rom_dout = r1_q;
    assign b2.rom_dout = r2_q2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard queues: 0 = IF/lat1, 1 = D/lat1, 2 = IF/lat2, 3 = D/lat2.
    exp_t     sb [4][$];
    string    pn [4] = '{"if_l1", "d_l1", "if_l2", "d_l2"};
    port_id_t m_last   = PORT_D;
    logic     prev_ce2 = 1'b0;

    always @(negedge clk) begin : predictor
        logic        g_if, g_d, ok;
        logic [31:0] a, off;
        exp_t        e;
        g_if = 1'b0;
        g_d  = 1'b0;
        if (reset) begin
            m_last = PORT_D;
            for (int k = 0; k < 4; k++) sb[k].delete();
        end else if (if_req && (!d_req || m_last == PORT_D)) g_if = 1'b1;
        else if (d_req) g_d = 1'b1;
        if (g_if) m_last = PORT_IF;
        else if (g_d) m_last = PORT_D;
        a   = g_d ? d_addr : if_addr;
        off = a - BASE;
        ok  = (g_if || g_d) && (off < 32'h1000) && (a[1:0] == 2'b00);
        chk("if_gnt_l1", b1.if_gnt, g_if);
        chk("d_gnt_l1", b1.d_gnt, g_d);
        chk("if_gnt_l2", b2.if_gnt, g_if);
        chk("d_gnt_l2", b2.d_gnt, g_d);
        chk("rom_ce_l1", b1.rom_ce, ok);
        chk("rom_ce_l2", b2.rom_ce, ok);
        chk("rom_ad_l1", b1.rom_ad, ok ? {22'b0, off[11:2]} : 32'h0);
        chk("rom_ad_l2", b2.rom_ad, ok ? {22'b0, off[11:2]} : 32'h0);
        chk("rom_oce_l1", b1.rom_oce, ok);
        chk("rom_oce_l2", b2.rom_oce, !reset && prev_ce2);
        prev_ce2 = ok;
        if (g_if || g_d) begin
            e.data = ok ? rom_word(off >> 2) : 32'h0;
            e.err  = !ok;
            e.due  = cyc + 1;
            sb[g_d ? 1 : 0].push_back(e);
            e.due  = cyc + 2;
            sb[g_d ? 3 : 2].push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        logic        rv [4];
        logic [31:0] rd [4];
        logic        er [4];
        exp_t        e;
        rv = '{b1.if_rvalid, b1.d_rvalid, b2.if_rvalid, b2.d_rvalid};
        rd = '{b1.if_rdata, b1.d_rdata, b2.if_rdata, b2.d_rdata};
        er = '{b1.if_err, b1.d_err, b2.if_err, b2.d_err};
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                chk({pn[k], "_rvalid_in_reset"}, rv[k], 1'b0);
            end else if (rv[k] === 1'b1) begin
                if (sb[k].size() == 0) begin
                    chk({pn[k], "_spurious_rvalid"}, 1'b1, 1'b0);
                end else begin
                    e = sb[k].pop_front();
                    chk({pn[k], "_latency"}, cyc, e.due);
                    chk({pn[k], "_rdata"}, rd[k], e.data);
                    chk({pn[k], "_err"}, er[k], e.err);
                end
            end else begin
                chk({pn[k], "_idle_rdata"}, rd[k], 32'h0);
                chk({pn[k], "_idle_err"}, er[k], 1'b0);
                if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
                    chk({pn[k], "_missing_rvalid"}, 1'b0, 1'b1);
                    void'(sb[k].pop_front());
                end
            end
        end
    end

    // Requesters: present the next queued address, hold it until granted.
    logic [31:0] if_q [$];
    logic [31:0] d_q [$];
    bit          gaps = 1'b0;

    task automatic tick();
        logic gi, gd;
        if (!if_req && if_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            if_req  = 1'b1;
            if_addr = if_q.pop_front();
        end
        if (!d_req && d_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            d_req  = 1'b1;
            d_addr = d_q.pop_front();
        end
        @(negedge clk);
        gi = b1.if_gnt;
        gd = b1.d_gnt;
        @(posedge clk);
        #1;
        if (gi) begin if_req = 1'b0; if_addr = '0; end
        if (gd) begin d_req  = 1'b0; d_addr  = '0; end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((if_q.size() > 0 || d_q.size() > 0 || if_req || d_req) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_within_budget", n < budget, 1'b1);
        repeat (3) tick();
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        if_addr = '0;
        d_addr  = '0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        if_addr = '0;
        d_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        if_q.push_back(32'h0);
        run(50);

        do_reset(1);
        repeat (4) begin
            if_q.push_back(32'h4);
            d_q.push_back(32'h8);
        end
        run(50);

        d_q.push_back(32'h6);
        d_q.push_back(32'h1000);
        run(50);

        if_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        run(50);

        if_req  = 1'b1;
        if_addr = 32'h0;
        tick();
        do_reset(1);
        if_q.push_back(32'h10);
        d_q.push_back(32'h14);
        run(50);

        if_q = '{32'hFFC, 32'h1000, 32'hFFFF_FFFC};
        d_q  = '{32'hFF8, 32'hFFF, 32'h0000_0FFE};
        run(50);

        gaps = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            int unsigned r;
            r = $urandom_range(9);
            if (r < 7)       a = {20'b0, 10'($urandom_range(1023)), 2'b00};
            else if (r == 7) a = {20'b0, 10'($urandom_range(1023)), 2'($urandom_range(3, 1))};
            else if (r == 8) a = 32'h1000 + $urandom_range(32'h0FFF_FFFF);
            else             a = 32'hFFC;
            if (i % 2 == 0) if_q.push_back(a);
            else            d_q.push_back(a);
        end
        run(3000);

        for (int k = 0; k < 4; k++) chk({pn[k], "_scoreboard_empty"}, sb[k].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
